imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_sync_edge.sv | 25 ++
 rtl/imem_loader.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the iMem pad loader: FSM state encoding and frame sizing.
package imem_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_FULL    = 2'd2,
      ST_WRITE   = 2'd3
   } state_t;

   // Bytes needed to carry one address+data word, rounded up to whole transfers.
   function automatic int frame_bytes(input int addr_w, input int data_w, input int in_w);
      return (addr_w + data_w + in_w - 1) / in_w;
   endfunction

endpackage

// File: rtl/imem_loader_sync_edge.sv
// Two-flop synchroniser for one asynchronous control line with rising-edge detect.
module sync_edge (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_rise
);

   logic r_s1, r_s2, r_prev;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1   <= 1'b0;
         r_s2   <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_s1   <= i_async;
         r_s2   <= r_s1;
         r_prev <= r_s2;
      end
   end

   assign o_rise = r_s2 & ~r_prev;

endmodule

// File: rtl/imem_loader.sv
// Pad-driven iMem loader: assembles byte frames into address+data writes.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int IN_WIDTH   = 8,
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 40
) (
   input  logic                  clk_int,
   input  logic                  reset,
   input  logic                  load_en,
   input  logic [IN_WIDTH-1:0]   pad_data,
   input  logic                  pad_strobe,
   input  logic                  pad_commit,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_write_adr,
   output logic [DATA_WIDTH-1:0] imem_in,
   output logic                  busy,
   output logic                  err_short,
   output logic                  err_overrun,
   output logic                  err_checksum,
   output logic [15:0]           word_count
);

   localparam int FRAME_BYTES = frame_bytes(ADDR_WIDTH, DATA_WIDTH, IN_WIDTH);
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam int CK_BYTES = 1;
`else
   localparam int CK_BYTES = 0;
`endif
   localparam int FRAME_LEN = FRAME_BYTES + CK_BYTES;
   localparam int CNT_W     = $clog2(FRAME_LEN + 1);
   localparam int SW        = ADDR_WIDTH + DATA_WIDTH;

   logic [IN_WIDTH-1:0] r_d1, r_d2;
   logic                w_str, w_cmt;
   state_t              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_base, w_cnt_nxt;
   logic [SW-1:0]       r_shift;
   logic                r_load_prev, w_load_rise;
   logic                w_clr, w_accept, w_data_byte, w_wc_inc, w_ck_bad;
   logic                w_set_short, w_set_over, w_set_ck;
   logic                r_err_short, r_err_over;
   logic [15:0]         r_wc;

   sync_edge u_strobe (.i_clk(clk_int), .i_rst(reset), .i_async(pad_strobe), .o_rise(w_str));
   sync_edge u_commit (.i_clk(clk_int), .i_rst(reset), .i_async(pad_commit), .o_rise(w_cmt));

   always_ff @(posedge clk_int) begin
      if (reset) begin
         r_d1 <= '0;
         r_d2 <= '0;
      end else begin
         r_d1 <= pad_data;
         r_d2 <= r_d1;
      end
   end

   assign w_load_rise = load_en & ~r_load_prev;

   always_ff @(posedge clk_int) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Commit is judged against the pre-strobe state; a same-cycle strobe is then
   // applied on top of any discard.
   always_comb begin
      w_state_nxt = r_state;
      w_clr       = 1'b0;
      w_accept    = 1'b0;
      w_set_short = 1'b0;
      w_set_over  = 1'b0;
      w_set_ck    = 1'b0;
      w_wc_inc    = 1'b0;
      case (r_state)
         ST_IDLE: if (load_en) w_state_nxt = ST_COLLECT;
         ST_COLLECT: begin
            if (!load_en) begin
               w_state_nxt = ST_IDLE;
               w_clr       = 1'b1;
            end else begin
               if (w_cmt) begin
                  w_set_short = 1'b1;
                  w_clr       = 1'b1;
               end
               w_accept = w_str;
            end
         end
         ST_FULL: begin
            if (!load_en) begin
               w_state_nxt = ST_IDLE;
               w_clr       = 1'b1;
            end else begin
               w_set_over = w_str;
               if (w_cmt) begin
                  if (w_ck_bad) begin
                     w_set_ck    = 1'b1;
                     w_clr       = 1'b1;
                     w_state_nxt = ST_COLLECT;
                  end else begin
                     w_state_nxt = ST_WRITE;
                  end
               end
            end
         end
         ST_WRITE: begin
            w_state_nxt = ST_COLLECT;
            w_clr       = 1'b1;
            w_wc_inc    = 1'b1;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      w_cnt_base = w_clr ? '0 : r_cnt;
      w_cnt_nxt  = w_cnt_base + CNT_W'(w_accept);
      if (r_state == ST_COLLECT && load_en && w_cnt_nxt == CNT_W'(FRAME_LEN))
         w_state_nxt = ST_FULL;
   end

   assign w_data_byte = w_accept && (w_cnt_base < CNT_W'(FRAME_BYTES));

   always_ff @(posedge clk_int) begin
      if (reset) begin
         r_cnt       <= '0;
         r_shift     <= '0;
         r_load_prev <= 1'b0;
         r_err_short <= 1'b0;
         r_err_over  <= 1'b0;
         r_wc        <= '0;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_load_prev <= load_en;
         if (w_data_byte)
            r_shift <= {(w_clr ? {(SW-IN_WIDTH){1'b0}} : r_shift[SW-IN_WIDTH-1:0]), r_d2};
         else if (w_clr)
            r_shift <= '0;
         if (w_load_rise) begin
            r_err_short <= 1'b0;
            r_err_over  <= 1'b0;
         end else begin
            r_err_short <= r_err_short | w_set_short;
            r_err_over  <= r_err_over  | w_set_over;
         end
         if (w_wc_inc) r_wc <= r_wc + 16'd1;
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [IN_WIDTH-1:0] r_xor, r_ck_rx;
   logic                r_err_ck;

   assign w_ck_bad     = (r_xor != r_ck_rx);
   assign err_checksum = r_err_ck;

   always_ff @(posedge clk_int) begin
      if (reset) begin
         r_xor    <= '0;
         r_ck_rx  <= '0;
         r_err_ck <= 1'b0;
      end else begin
         if (w_load_rise)   r_err_ck <= 1'b0;
         else if (w_set_ck) r_err_ck <= 1'b1;
         if (w_data_byte)   r_xor   <= (w_clr ? '0 : r_xor) ^ r_d2;
         else if (w_clr)    r_xor   <= '0;
         if (w_accept && !w_data_byte) r_ck_rx <= r_d2;
      end
   end
`else
   assign w_ck_bad     = 1'b0;
   assign err_checksum = 1'b0;
`endif

   assign imem_we        = (r_state == ST_WRITE);
   assign busy           = (r_state != ST_IDLE);
   assign imem_in        = r_shift[DATA_WIDTH-1:0];
   assign imem_write_adr = r_shift[SW-1:DATA_WIDTH];
   assign err_short      = r_err_short;
   assign err_overrun    = r_err_over;
   assign word_count     = r_wc;

endmodule
